// File: rtl/bridge_arbiter.sv
// bridge_arbiter -- round-robin arbiter/sequencer sharing one bridge command
// channel between NUM_REQ client requesters, one transaction at a time.
//
// Optional feature macro: BRIDGE_ARB_HIT_CACHE_EN (one-entry read cache,
// adds output port cache_hit).
//
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   req_valid       per-requester request level (held until its rsp_valid)
//   req_r_wb        per-requester direction, 1=read 0=write
//   req_addr        packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_data_w      packed write data, same packing
//   rsp_valid       one-cycle completion pulse, at most one bit set
//   rsp_data_r      read data while rsp_valid!=0, else 0
//   busy            high whenever the sequencer is not idle
//   grant_id        index of current/last granted requester
//   cache_hit       (cache build only) pulses with rsp_valid on a cache hit
//   C_in_valid, C_r_wb, C_addr, C_data_w   command to bridge
//   C_out_valid, C_data_r                  completion from bridge
module bridge_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 64
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ-1:0]        req_r_wb,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_data_w,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_data_r,
   output logic                      busy,
   output logic [2:0]                grant_id,
`ifdef BRIDGE_ARB_HIT_CACHE_EN
   output logic                      cache_hit,
`endif
   output logic                      C_in_valid,
   output logic                      C_r_wb,
   output logic [ADDR_W-1:0]         C_addr,
   output logic [DATA_W-1:0]         C_data_w,
   input  logic                      C_out_valid,
   input  logic [DATA_W-1:0]         C_data_r
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   state_t state_r;
   logic [2:0] last_r;

   logic              win_found_s;
   logic [2:0]        win_id_s;
   logic              win_r_wb_s;
   logic [ADDR_W-1:0] win_addr_s;
   logic [DATA_W-1:0] win_data_s;
   logic              take_s;
   int                dist_s;
   int                best_s;

`ifdef BRIDGE_ARB_HIT_CACHE_EN
   logic              cache_valid_r;
   logic [ADDR_W-1:0] cache_addr_r;
   logic [DATA_W-1:0] cache_data_r;
   logic              hit_s;
`endif

   // One-hot response vector for a requester index.
   function automatic logic [NUM_REQ-1:0] onehot(input logic [2:0] id);
      onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << id;
   endfunction

   // Round-robin search: the pending requester closest after last_r wins.
   // Distance 0 means last_r+1, so the previous winner is considered last.
   always_comb begin
      win_found_s = 1'b0;
      win_id_s    = 3'd0;
      win_r_wb_s  = 1'b0;
      win_addr_s  = {ADDR_W{1'b0}};
      win_data_s  = {DATA_W{1'b0}};
      best_s      = NUM_REQ;
      dist_s      = 0;
      take_s      = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         dist_s      = (i + NUM_REQ - int'(last_r) - 1) % NUM_REQ;
         take_s      = req_valid[i] && (dist_s < best_s);
         best_s      = take_s ? dist_s : best_s;
         win_found_s = win_found_s | take_s;
         win_id_s    = take_s ? i[2:0] : win_id_s;
         win_r_wb_s  = take_s ? req_r_wb[i] : win_r_wb_s;
         win_addr_s  = take_s ? req_addr[i*ADDR_W +: ADDR_W] : win_addr_s;
         win_data_s  = take_s ? req_data_w[i*DATA_W +: DATA_W] : win_data_s;
      end
   end

`ifdef BRIDGE_ARB_HIT_CACHE_EN
   // A read whose address matches the valid cache entry is served locally.
   always_comb begin
      hit_s = win_r_wb_s && cache_valid_r && (cache_addr_r == win_addr_s);
   end
`endif

   // Sequencer: arbitrate, issue one bridge command, wait, respond.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         last_r     <= 3'(NUM_REQ - 1);
         grant_id   <= 3'd0;
         rsp_valid  <= {NUM_REQ{1'b0}};
         rsp_data_r <= {DATA_W{1'b0}};
         busy       <= 1'b0;
         C_in_valid <= 1'b0;
         C_r_wb     <= 1'b0;
         C_addr     <= {ADDR_W{1'b0}};
         C_data_w   <= {DATA_W{1'b0}};
`ifdef BRIDGE_ARB_HIT_CACHE_EN
         cache_hit     <= 1'b0;
         cache_valid_r <= 1'b0;
         cache_addr_r  <= {ADDR_W{1'b0}};
         cache_data_r  <= {DATA_W{1'b0}};
`endif
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (win_found_s) begin
                  grant_id <= win_id_s;
                  last_r   <= win_id_s;
                  C_r_wb   <= win_r_wb_s;
                  C_addr   <= win_addr_s;
                  C_data_w <= win_data_s;
                  busy     <= 1'b1;
`ifdef BRIDGE_ARB_HIT_CACHE_EN
                  if (hit_s) begin
                     rsp_valid  <= onehot(win_id_s);
                     rsp_data_r <= cache_data_r;
                     cache_hit  <= 1'b1;
                     state_r    <= ST_RESP;
                  end else begin
                     // Writes update the entry now but still go to the bridge.
                     if (!win_r_wb_s) begin
                        cache_valid_r <= 1'b1;
                        cache_addr_r  <= win_addr_s;
                        cache_data_r  <= win_data_s;
                     end
                     C_in_valid <= 1'b1;
                     state_r    <= ST_ISSUE;
                  end
`else
                  C_in_valid <= 1'b1;
                  state_r    <= ST_ISSUE;
`endif
               end
            end
            ST_ISSUE: begin
               C_in_valid <= 1'b0;
               state_r    <= ST_WAIT;
            end
            ST_WAIT: begin
               if (C_out_valid) begin
                  rsp_valid  <= onehot(grant_id);
                  rsp_data_r <= C_r_wb ? C_data_r : {DATA_W{1'b0}};
                  state_r    <= ST_RESP;
`ifdef BRIDGE_ARB_HIT_CACHE_EN
                  if (C_r_wb) begin
                     cache_valid_r <= 1'b1;
                     cache_addr_r  <= C_addr;
                     cache_data_r  <= C_data_r;
                  end
`endif
               end
            end
            ST_RESP: begin
               rsp_valid  <= {NUM_REQ{1'b0}};
               rsp_data_r <= {DATA_W{1'b0}};
               busy       <= 1'b0;
               state_r    <= ST_IDLE;
`ifdef BRIDGE_ARB_HIT_CACHE_EN
               cache_hit  <= 1'b0;
`endif
            end
            default: begin
               rsp_valid  <= {NUM_REQ{1'b0}};
               rsp_data_r <= {DATA_W{1'b0}};
               busy       <= 1'b0;
               C_in_valid <= 1'b0;
               state_r    <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bridge_arbiter.sv
// Self-checking bench for bridge_arbiter: directed scenarios followed by
// randomized traffic, checked against a behavioural model of the arbiter
// (round-robin by rule, bridge responses supplied by the bench, optional
// one-entry cache tracked in plain variables).
module tb_bridge_arbiter;
   localparam int NUM_REQ = 4;
   localparam int ADDR_W  = 8;
   localparam int DATA_W  = 64;

   logic                      clk = 1'b0;
   logic                      rst_n = 1'b0;
   logic [NUM_REQ-1:0]        req_valid = '0;
   logic [NUM_REQ-1:0]        req_r_wb = '0;
   logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
   logic [NUM_REQ*DATA_W-1:0] req_data_w = '0;
   logic [NUM_REQ-1:0]        rsp_valid;
   logic [DATA_W-1:0]         rsp_data_r;
   logic                      busy;
   logic [2:0]                grant_id;
   logic                      C_in_valid;
   logic                      C_r_wb;
   logic [ADDR_W-1:0]         C_addr;
   logic [DATA_W-1:0]         C_data_w;
   logic                      C_out_valid = 1'b0;
   logic [DATA_W-1:0]         C_data_r = '0;
`ifdef BRIDGE_ARB_HIT_CACHE_EN
   logic                      cache_hit;
`endif

   int total = 0;
   int bad   = 0;
   int exp_last;
   int w;
   logic              mc_valid;
   logic [ADDR_W-1:0] mc_addr;
   logic [DATA_W-1:0] mc_data;

   bridge_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_r_wb(req_r_wb),
      .req_addr(req_addr), .req_data_w(req_data_w),
      .rsp_valid(rsp_valid), .rsp_data_r(rsp_data_r),
      .busy(busy), .grant_id(grant_id),
`ifdef BRIDGE_ARB_HIT_CACHE_EN
      .cache_hit(cache_hit),
`endif
      .C_in_valid(C_in_valid), .C_r_wb(C_r_wb), .C_addr(C_addr),
      .C_data_w(C_data_w), .C_out_valid(C_out_valid), .C_data_r(C_data_r)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero_outs(input string tag);
      chk({tag, "_rsp"}, 64'(rsp_valid), 64'd0);
      chk({tag, "_rdata"}, rsp_data_r, 64'd0);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_gid"}, 64'(grant_id), 64'd0);
      chk({tag, "_cinv"}, 64'(C_in_valid), 64'd0);
      chk({tag, "_crwb"}, 64'(C_r_wb), 64'd0);
      chk({tag, "_caddr"}, 64'(C_addr), 64'd0);
      chk({tag, "_cdata"}, C_data_w, 64'd0);
`ifdef BRIDGE_ARB_HIT_CACHE_EN
      chk({tag, "_hit"}, 64'(cache_hit), 64'd0);
`endif
   endtask

   task automatic set_req(input int i, input logic rwb, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d);
      req_valid[i] = 1'b1;
      req_r_wb[i]  = rwb;
      req_addr[i*ADDR_W +: ADDR_W]   = a;
      req_data_w[i*DATA_W +: DATA_W] = d;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req_valid = '0; req_r_wb = '0; req_addr = '0; req_data_w = '0;
      C_out_valid = 1'b0; C_data_r = '0;
      exp_last = NUM_REQ - 1;
      mc_valid = 1'b0; mc_addr = '0; mc_data = '0;
      @(negedge clk);
      chk_zero_outs("reset");
      rst_n = 1'b1;
      @(negedge clk);
      chk_zero_outs("post_reset_idle");
   endtask

   // One arbitrated transaction. exp_wait: negedges until the grant becomes
   // visible (1 from an idle start, 2 right after a response). k: bridge
   // latency in cycles counted from the C_in_valid cycle (t+1 .. t+k).
   // Returns at the negedge of the response cycle, with the winner in win.
   task automatic txn(input int exp_wait, input int k, input logic [DATA_W-1:0] bdata,
                      output int win);
      logic rwb, hit;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d, exp_d;
      logic [NUM_REQ-1:0] oh;
      win = -1;
      for (int s = 1; s <= NUM_REQ; s++) begin
         int c;
         c = (exp_last + s) % NUM_REQ;
         if (win < 0 && req_valid[c]) win = c;
      end
      if (win < 0) begin
         chk("no_request_pending", 64'd0, 64'd1);
         win = 0;
      end
      exp_last = win;
      rwb = req_r_wb[win];
      a   = req_addr[win*ADDR_W +: ADDR_W];
      d   = req_data_w[win*DATA_W +: DATA_W];
      oh  = '0;
      oh[win] = 1'b1;
      hit = 1'b0;
`ifdef BRIDGE_ARB_HIT_CACHE_EN
      hit = rwb && mc_valid && (mc_addr == a);
      if (!rwb) begin
         mc_valid = 1'b1; mc_addr = a; mc_data = d;
      end
`endif
      for (int i = 1; i < exp_wait; i++) begin
         @(negedge clk);
         chk("idle_cinv", 64'(C_in_valid), 64'd0);
         chk("idle_rsp", 64'(rsp_valid), 64'd0);
         chk("idle_busy", 64'(busy), 64'd0);
      end
      @(negedge clk);
      chk("grant_id", 64'(grant_id), 64'(win));
      chk("grant_busy", 64'(busy), 64'd1);
      if (hit) begin
         chk("hit_cinv", 64'(C_in_valid), 64'd0);
         chk("hit_rsp", 64'(rsp_valid), 64'(oh));
         chk("hit_data", rsp_data_r, mc_data);
`ifdef BRIDGE_ARB_HIT_CACHE_EN
         chk("hit_flag", 64'(cache_hit), 64'd1);
`endif
      end else begin
         chk("issue_cinv", 64'(C_in_valid), 64'd1);
         chk("issue_rwb", 64'(C_r_wb), 64'(rwb));
         chk("issue_addr", 64'(C_addr), 64'(a));
         chk("issue_dataw", C_data_w, d);
         chk("issue_rsp", 64'(rsp_valid), 64'd0);
         // Granted requester's fields change after the grant; must be ignored.
         req_addr[win*ADDR_W +: ADDR_W]   = ~a;
         req_data_w[win*DATA_W +: DATA_W] = ~d;
         for (int i = 0; i < k - 1; i++) begin
            @(negedge clk);
            chk("wait_cinv", 64'(C_in_valid), 64'd0);
            chk("wait_rsp", 64'(rsp_valid), 64'd0);
            chk("wait_rdata", rsp_data_r, 64'd0);
            chk("wait_busy", 64'(busy), 64'd1);
            chk("wait_rwb", 64'(C_r_wb), 64'(rwb));
            chk("wait_addr", 64'(C_addr), 64'(a));
            chk("wait_dataw", C_data_w, d);
         end
         C_out_valid = 1'b1;
         C_data_r    = bdata;
         @(negedge clk);
         C_out_valid = 1'b0;
         C_data_r    = {$urandom, $urandom};
         exp_d = rwb ? bdata : 64'd0;
`ifdef BRIDGE_ARB_HIT_CACHE_EN
         if (rwb) begin
            mc_valid = 1'b1; mc_addr = a; mc_data = bdata;
         end
         chk("miss_flag", 64'(cache_hit), 64'd0);
`endif
         chk("rsp_valid", 64'(rsp_valid), 64'(oh));
         chk("rsp_data", rsp_data_r, exp_d);
         chk("rsp_busy", 64'(busy), 64'd1);
         chk("rsp_cinv", 64'(C_in_valid), 64'd0);
      end
   endtask

   initial begin
      // Reset state.
      do_reset();

      // Single read from requester 0, bridge latency 5.
      set_req(0, 1'b1, 8'h12, 64'h0);
      txn(1, 5, 64'hDEAD_BEEF_0000_0001, w);
      chk("single_read_winner", 64'(w), 64'd0);
      req_valid = '0;

      // Write from requester 2.
      set_req(2, 1'b0, 8'hFF, 64'h0123_4567_89AB_CDEF);
      txn(2, 3, 64'h5555_5555_5555_5555, w);
      chk("write_winner", 64'(w), 64'd2);
      req_valid = '0;

      // All four requesting and held: strict rotation starting at 0.
      do_reset();
      for (int i = 0; i < NUM_REQ; i++)
         set_req(i, i[0], 8'(8'h50 + i), {32'hC0DE_0000, 32'(i)});
      for (int j = 0; j < 5; j++) begin
         txn((j == 0) ? 1 : 2, 2 + (j % 3), {32'hFACE_0000, 32'(j)}, w);
         chk("rr_order", 64'(w), 64'(j % NUM_REQ));
      end
      req_valid = '0;

      // Requester 1 re-requests immediately while requester 3 waits.
      set_req(1, 1'b0, 8'h60, 64'h11);
      txn(2, 2, 64'h0, w);
      chk("rereq_first", 64'(w), 64'd1);
      set_req(1, 1'b0, 8'h34, 64'h3434);
      set_req(3, 1'b1, 8'h70, 64'h0);
      txn(2, 2, 64'h7070, w);
      chk("rereq_r3", 64'(w), 64'd3);
      req_valid[3] = 1'b0;
      txn(2, 2, 64'h0, w);
      chk("rereq_r1", 64'(w), 64'd1);
      chk("rereq_addr", 64'(C_addr), 64'h34);
      req_valid = '0;

      // Reset asserted while waiting on the bridge.
      @(negedge clk);
      set_req(2, 1'b1, 8'h44, 64'h0);
      @(negedge clk);
      chk("rstw_cinv", 64'(C_in_valid), 64'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_zero_outs("rst_in_wait");
      exp_last = NUM_REQ - 1;
      mc_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      req_valid = '0;
      @(negedge clk);
      C_out_valid = 1'b1;
      C_data_r = 64'hBAD0_BAD0_BAD0_BAD0;
      @(negedge clk);
      C_out_valid = 1'b0;
      chk("stray_cov_rsp", 64'(rsp_valid), 64'd0);
      chk("stray_cov_busy", 64'(busy), 64'd0);
      @(negedge clk);
      chk("stray_cov_rsp2", 64'(rsp_valid), 64'd0);
      set_req(0, 1'b1, 8'h01, 64'h0);
      set_req(3, 1'b1, 8'h03, 64'h0);
      txn(1, 2, 64'h0101, w);
      chk("after_rst_winner", 64'(w), 64'd0);
      req_valid = '0;

`ifdef BRIDGE_ARB_HIT_CACHE_EN
      // Cache: write then read same address hits, neighbour misses.
      set_req(1, 1'b0, 8'h20, 64'hA5);
      txn(2, 2, 64'h0, w);
      req_valid = '0;
      set_req(1, 1'b1, 8'h20, 64'h0);
      txn(2, 2, 64'h0, w);
      chk("cache_hit_data", rsp_data_r, 64'hA5);
      chk("cache_hit_flag", 64'(cache_hit), 64'd1);
      req_valid = '0;
      set_req(1, 1'b1, 8'h21, 64'h0);
      txn(2, 3, 64'h2121, w);
      chk("cache_miss_flag", 64'(cache_hit), 64'd0);
      chk("cache_miss_data", rsp_data_r, 64'h2121);
      req_valid = '0;
`endif

      // Randomized traffic.
      set_req(int'($urandom_range(NUM_REQ - 1, 0)), 1'($urandom), 8'(8'h80 + $urandom_range(3, 0)),
              {$urandom, $urandom});
      for (int n = 0; n < 60; n++) begin
         txn(2, int'($urandom_range(5, 2)), {$urandom, $urandom}, w);
         if ($urandom_range(1, 0) == 1)
            set_req(w, 1'($urandom), 8'(8'h80 + $urandom_range(3, 0)), {$urandom, $urandom});
         else
            req_valid[w] = 1'b0;
         for (int i = 0; i < NUM_REQ; i++)
            if (!req_valid[i] && $urandom_range(2, 0) == 0)
               set_req(i, 1'($urandom), 8'(8'h80 + $urandom_range(3, 0)), {$urandom, $urandom});
         if (req_valid == '0)
            set_req(int'($urandom_range(NUM_REQ - 1, 0)), 1'($urandom),
                    8'(8'h80 + $urandom_range(3, 0)), {$urandom, $urandom});
      end
      req_valid = '0;
      @(negedge clk);
      @(negedge clk);
      chk("final_idle_busy", 64'(busy), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
